// File: rtl/pipeline_stage_reg_if.sv
// Valid/ready handshake bundle for one elastic pipeline stage.
// The slave side is the stage register itself; the master side is the
// environment that feeds upstream payloads and drains downstream ones.
interface pipeline_stage_reg_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  IN_VALID;
    logic [DATA_WIDTH-1:0] IN_DATA;
    logic                  IN_READY;
    logic                  OUT_VALID;
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic                  OUT_READY;

    modport slave (
        input  IN_VALID,
        input  IN_DATA,
        output IN_READY,
        output OUT_VALID,
        output OUT_DATA,
        input  OUT_READY
    );

    modport master (
        output IN_VALID,
        output IN_DATA,
        input  IN_READY,
        input  OUT_VALID,
        input  OUT_DATA,
        output OUT_READY
    );
endinterface

// File: rtl/pipeline_stage_reg.sv
// Elastic pipeline register with a two-entry skid buffer.
// MAIN drives the output; SKID absorbs one extra payload when downstream
// stalls, so IN_READY only depends on registered state plus the global
// BUSYWAIT/FLUSH controls and never on OUT_READY.
module pipeline_stage_reg #(
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       BUSYWAIT,
    input  logic                       FLUSH,
    pipeline_stage_reg_if.slave        bus,
    output logic [1:0]                 OCCUPANCY
);

    // State encoding equals the number of held entries.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q,  main_d;
    logic [DATA_WIDTH-1:0] skid_q,  skid_d;

    logic in_ready;
    logic out_valid;
    logic in_fire;
    logic out_fire;

    // RESET_N gates IN_READY so nothing is reported accepted while in reset.
    assign in_ready  = (state_q != ST_FULL) & ~BUSYWAIT & ~FLUSH & RESET_N;
    assign out_valid = (state_q != ST_EMPTY) & ~BUSYWAIT;
    assign in_fire   = bus.IN_VALID & in_ready;
    assign out_fire  = out_valid & bus.OUT_READY;

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_DATA  = main_q;
    assign OCCUPANCY     = state_q;

    // Next-state and storage update: flush first, then freeze, then handshake.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VALUE;
            skid_d  = RESET_VALUE;
        end else if (!BUSYWAIT) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = bus.IN_DATA;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.IN_DATA;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = bus.IN_DATA;
                    end else if (out_fire) begin
                        // MAIN keeps its stale value; OUT_VALID hides it.
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and payload registers; asynchronous reset clears both entries.
    always_ff @(posedge CLK or negedge RESET_N) begin
        // NOTE: the payload registers are reset too, because OUT_DATA must
        // show RESET_VALUE straight out of reset, not whatever was left over.
        if (!RESET_N) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed bench for pipeline_stage_reg: reset, skid/backpressure, BUSYWAIT
// freeze and FLUSH via a vector table, then reset-in-flight and streaming
// on a 64-bit instance and a 32-bit instance with a NOP reset value.
module tb_pipeline_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic       CLK;
    logic       RESET_N;
    logic       BUSYWAIT;
    logic       FLUSH;
    logic [1:0] occ_w;
    logic [1:0] occ_n;

    pipeline_stage_reg_if #(.DATA_WIDTH(64)) bus_w ();
    pipeline_stage_reg_if #(.DATA_WIDTH(32)) bus_n ();

    pipeline_stage_reg #(
        .DATA_WIDTH (64),
        .RESET_VALUE(64'h0)
    ) dut_w (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .BUSYWAIT (BUSYWAIT),
        .FLUSH    (FLUSH),
        .bus      (bus_w),
        .OCCUPANCY(occ_w)
    );

    pipeline_stage_reg #(
        .DATA_WIDTH (32),
        .RESET_VALUE(NOP)
    ) dut_n (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .BUSYWAIT (BUSYWAIT),
        .FLUSH    (FLUSH),
        .bus      (bus_n),
        .OCCUPANCY(occ_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [63:0] din;
        logic        ordy;
        logic        bw;
        logic        fl;
        logic        exp_ir;
        logic        exp_ov;
        logic [63:0] exp_dout;
        logic [1:0]  exp_occ;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    initial begin
        logic [63:0] pay_w [8];
        logic [31:0] pay_n [8];

        // Outputs are checked before the edge that consumes each row's inputs.
        //            iv din    ordy bw fl  ir ov dout    occ
        vecs[0]  = '{1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 2'd0};
        vecs[1]  = '{1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'hA, 2'd1};
        vecs[2]  = '{1'b1, 64'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hA, 2'd2};
        vecs[3]  = '{1'b1, 64'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hA, 2'd2};
        vecs[4]  = '{1'b1, 64'hC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'hB, 2'd1};
        vecs[5]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'hC, 2'd1};
        vecs[6]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'hC, 2'd0};
        vecs[7]  = '{1'b1, 64'hD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'hC, 2'd0};
        vecs[8]  = '{1'b1, 64'hE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'hD, 2'd1};
        vecs[9]  = '{1'b1, 64'hE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'hD, 2'd1};
        vecs[10] = '{1'b1, 64'hE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'hD, 2'd1};
        vecs[11] = '{1'b1, 64'hE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'hD, 2'd1};
        vecs[12] = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'hE, 2'd1};
        vecs[13] = '{1'b1, 64'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'hE, 2'd1};
        vecs[14] = '{1'b1, 64'h7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'hE, 2'd2};
        vecs[15] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 2'd0};
        vecs[16] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 2'd0};
        vecs[17] = '{1'b1, 64'h8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 2'd0};
        vecs[18] = '{1'b1, 64'h9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h8, 2'd1};
        vecs[19] = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 2'd0};

        for (int i = 0; i < 8; i++) begin
            pay_w[i] = {32'(i * 4), NOP};
            pay_n[i] = 32'(i << 20) | NOP;
        end

        RESET_N         = 1'b1;
        BUSYWAIT        = 1'b0;
        FLUSH           = 1'b0;
        bus_w.IN_VALID  = 1'b0;
        bus_w.IN_DATA   = '0;
        bus_w.OUT_READY = 1'b0;
        bus_n.IN_VALID  = 1'b0;
        bus_n.IN_DATA   = '0;
        bus_n.OUT_READY = 1'b0;

        // Reset asserted between edges must take effect without a clock.
        #2 RESET_N = 1'b0;
        #1;
        check("rst_out_data",  bus_w.OUT_DATA,  64'h0);
        check("rst_out_valid", bus_w.OUT_VALID, 64'h0);
        check("rst_in_ready",  bus_w.IN_READY,  64'h0);
        check("rst_occupancy", occ_w,           64'h0);
        check("rst_nop_data",  bus_n.OUT_DATA,  {32'h0, NOP});
        tick();
        tick();
        RESET_N = 1'b1;
        #1;
        check("rel_in_ready",   bus_w.IN_READY, 64'h1);
        check("rel_in_ready_n", bus_n.IN_READY, 64'h1);

        // Table: backpressure/skid, BUSYWAIT freeze, FLUSH cases.
        for (int i = 0; i < NV; i++) begin
            bus_w.IN_VALID  = vecs[i].iv;
            bus_w.IN_DATA   = vecs[i].din;
            bus_w.OUT_READY = vecs[i].ordy;
            BUSYWAIT        = vecs[i].bw;
            FLUSH           = vecs[i].fl;
            #1;
            check($sformatf("v%0d_in_ready", i),  bus_w.IN_READY,  64'(vecs[i].exp_ir));
            check($sformatf("v%0d_out_valid", i), bus_w.OUT_VALID, 64'(vecs[i].exp_ov));
            check($sformatf("v%0d_out_data", i),  bus_w.OUT_DATA,  vecs[i].exp_dout);
            check($sformatf("v%0d_occupancy", i), occ_w,           64'(vecs[i].exp_occ));
            tick();
        end

        // Reset in flight: fill both entries, then drop RESET_N between edges.
        bus_w.IN_VALID  = 1'b1;
        bus_w.IN_DATA   = 64'h55;
        bus_w.OUT_READY = 1'b0;
        BUSYWAIT        = 1'b0;
        FLUSH           = 1'b0;
        tick();
        bus_w.IN_DATA = 64'h66;
        tick();
        check("fill_occupancy", occ_w, 64'd2);
        #2 RESET_N = 1'b0;
        #1;
        check("mid_rst_occupancy", occ_w,           64'd0);
        check("mid_rst_out_valid", bus_w.OUT_VALID, 64'h0);
        check("mid_rst_out_data",  bus_w.OUT_DATA,  64'h0);
        check("mid_rst_in_ready",  bus_w.IN_READY,  64'h0);
        bus_w.IN_VALID = 1'b0;
        tick();
        RESET_N = 1'b1;
        bus_w.OUT_READY = 1'b1;
        #1;
        check("mid_rel_out_valid", bus_w.OUT_VALID, 64'h0);
        tick();
        check("mid_rel_no_skid", bus_w.OUT_VALID, 64'h0);

        // Streaming on both widths: one payload per cycle, one-cycle latency.
        bus_w.OUT_READY = 1'b1;
        bus_n.OUT_READY = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            bus_w.IN_VALID = (k < 8);
            bus_n.IN_VALID = (k < 8);
            bus_w.IN_DATA  = (k < 8) ? pay_w[k] : 64'h0;
            bus_n.IN_DATA  = (k < 8) ? pay_n[k] : 32'h0;
            #1;
            check($sformatf("s%0d_in_ready", k),   bus_w.IN_READY, 64'h1);
            check($sformatf("s%0d_in_ready_n", k), bus_n.IN_READY, 64'h1);
            if (k == 0) begin
                check("s0_out_valid",   bus_w.OUT_VALID, 64'h0);
                check("s0_out_valid_n", bus_n.OUT_VALID, 64'h0);
                check("s0_out_data_n",  bus_n.OUT_DATA,  {32'h0, NOP});
            end else begin
                check($sformatf("s%0d_out_valid", k),   bus_w.OUT_VALID, 64'h1);
                check($sformatf("s%0d_out_data", k),    bus_w.OUT_DATA,  pay_w[k-1]);
                check($sformatf("s%0d_out_valid_n", k), bus_n.OUT_VALID, 64'h1);
                check($sformatf("s%0d_out_data_n", k),  bus_n.OUT_DATA,  {32'h0, pay_n[k-1]});
                check($sformatf("s%0d_occupancy", k),   occ_w,           64'd1);
            end
            tick();
        end
        #1;
        check("s_drain_out_valid",   bus_w.OUT_VALID, 64'h0);
        check("s_drain_out_valid_n", bus_n.OUT_VALID, 64'h0);
        check("s_drain_occupancy",   occ_w,           64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_reg.md
# pipeline_stage_reg

Parametrised elastic pipeline register placed between any two RV32IM pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a DATA_WIDTH payload, for example a PC and instruction, under a valid/ready handshake. A two-entry skid buffer keeps IN_READY fully registered. It adds a synchronous FLUSH for branch/jump squash and a global BUSYWAIT freeze for memory stalls, and every output has a defined reset value.

## Interface
- DATA_WIDTH, 64, payload width in bits (64 = {PC[31:0], INSTRUCTION[31:0]} for IF/ID).
- RESET_VALUE, {DATA_WIDTH{1'b0}}, value driven on OUT_DATA after reset or flush (e.g. NOP 0x00000013 in the low word).
- CLK  input  1  clock; all state changes on posedge.
- RESET_N  input  1  reset, asynchronous, active-low.
- BUSYWAIT  input  1  global stall from memory; freezes the stage.
- FLUSH  input  1  synchronous squash of all held entries.
- IN_VALID  input  1  upstream payload valid.
- IN_DATA  input  DATA_WIDTH  upstream payload.
- IN_READY  output  1  stage can accept IN_DATA this cycle.
- OUT_VALID  output  1  OUT_DATA valid for downstream.
- OUT_DATA  output  DATA_WIDTH  payload at head of stage.
- OUT_READY  input  1  downstream accepts OUT_DATA.
- OCCUPANCY  output  2  entries held: 0, 1 or 2.

## Operation
- Storage:
  - MAIN register drives OUT_DATA.
  - SKID register captures one extra entry when downstream stalls.
- States are EMPTY (0 entries), ONE (MAIN valid) and FULL (MAIN and SKID valid). OCCUPANCY encodes the state directly.
- Handshake signals:
  - IN_READY = (state != FULL) & !BUSYWAIT & !FLUSH.
  - OUT_VALID = (state != EMPTY) & !BUSYWAIT.
  - in_fire = IN_VALID & IN_READY.
  - out_fire = OUT_VALID & OUT_READY.
- Transitions, applied only when FLUSH=0 and BUSYWAIT=0:
  - EMPTY:
    - in_fire → ONE, MAIN<=IN_DATA.
    - Otherwise hold.
  - ONE:
    - in_fire & out_fire → ONE, MAIN<=IN_DATA.
    - in_fire only → FULL, SKID<=IN_DATA.
    - out_fire only → EMPTY, MAIN holds its stale value.
  - FULL:
    - out_fire → ONE, MAIN<=SKID.
    - IN_READY is 0 in FULL, so no input is accepted.
- FLUSH=1 at posedge:
  - State → EMPTY.
  - MAIN<=RESET_VALUE and SKID<=RESET_VALUE.
  - Takes priority over BUSYWAIT and over any handshake.
  - IN_READY is held 0, so no upstream data is reported accepted and then lost.
- BUSYWAIT=1:
  - No register or state changes.
  - IN_READY=0 and OUT_VALID=0, so no transfer can complete.
  - OUT_DATA keeps showing MAIN.
- Payload is never modified, truncated or reordered. Ordering is strictly FIFO, depth 2.

## Timing
- Reset (RESET_N=0) acts immediately, without waiting for a clock edge:
  - State=EMPTY, MAIN=SKID=RESET_VALUE.
  - OUT_DATA=RESET_VALUE, OUT_VALID=0, IN_READY=0, OCCUPANCY=0.
- Release: IN_READY rises combinationally once RESET_N=1 and BUSYWAIT=FLUSH=0. The first accepted posedge is the first after release.
- Reset asserted mid-operation discards both entries with no partial update.
- Latency: in_fire at edge N → OUT_VALID=1 and OUT_DATA=IN_DATA after edge N, when the stage was EMPTY or ONE with out_fire.
- Throughput: 1 payload/cycle sustained while OUT_READY=1.
- IN_READY depends only on registered state plus BUSYWAIT/FLUSH, never on OUT_READY. The OUT_READY → IN_READY combinational path is broken.
- Simultaneous events:
  - in_fire and out_fire in ONE: net occupancy unchanged, new data in MAIN.
  - FLUSH with in_fire: impossible, because IN_READY=0.
  - FLUSH with BUSYWAIT: flush wins.
- Downstream may deassert OUT_READY at any cycle. Upstream must hold IN_DATA/IN_VALID until in_fire.

## Test plan
- Reset/defaults:
  - Stimulus: RESET_N low mid-cycle, no clock edge, then release.
  - Required: OUT_DATA=RESET_VALUE, OUT_VALID=0, OCCUPANCY=0 immediately on RESET_N low; IN_READY=1 after release.
- Streaming:
  - Stimulus: 8 payloads 0x00000000_00000013 … 0x0000001C_00000013 with OUT_READY=1.
  - Required: each appears on OUT_DATA 1 cycle after acceptance, in order, no gaps.
- Backpressure/skid:
  - Stimulus: OUT_READY=0 while pushing A, B, C.
  - Required:
    - A and B accepted; OCCUPANCY=2; IN_READY=0; C held upstream.
    - After OUT_READY=1, outputs are A, B, C in consecutive cycles.
- BUSYWAIT freeze:
  - Stimulus: BUSYWAIT=1 for 3 cycles with OCCUPANCY=1 and IN_VALID=1.
  - Required: OUT_VALID=0, IN_READY=0, OCCUPANCY and OUT_DATA unchanged; normal flow resumes the cycle after deassertion.
- Flush:
  - Stimulus: FLUSH=1 for one edge with OCCUPANCY=2 and BUSYWAIT=1.
  - Required: after that edge OCCUPANCY=0, OUT_VALID=0, OUT_DATA=RESET_VALUE; neither held entry is ever output.
- Parametrisation: repeat the streaming test with DATA_WIDTH=32 and RESET_VALUE=0x00000013; the same behaviour is required.
